// File: rtl/bit_output.sv
// bit_output: bit-serial transmitter that streams MSG_LEN bytes from a byte memory over valid/ready.
// Define BIT_OUTPUT_PARITY_EN to append an even-parity bit after each byte.
module bit_output #(
    parameter int MSG_LEN   = 16,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       rd_en,
    output logic [3:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       bit_out,
    output logic       bit_valid,
    input  logic       bit_ready,
    output logic       bit_last,
    output logic       busy,
    output logic       done
);

`ifdef BIT_OUTPUT_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd8;
`else
    localparam logic [3:0] LAST_BIT = 4'd7;
`endif
    localparam logic [3:0] LAST_ADDR = 4'(MSG_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t     state;
    logic [7:0] shreg;
    logic [3:0] bit_cnt;
    logic       fill;
    logic       accept;

`ifdef BIT_OUTPUT_PARITY_EN
    logic parity;

    // Filling the vacated end with the parity bit leaves it at the output after bit 7.
    always_ff @(posedge clk) begin
        if (reset)
            parity <= 1'b0;
        else if (state == LOAD)
            parity <= ^rd_data;
    end

    assign fill = parity;
`else
    assign fill = 1'b0;
`endif

    assign accept   = bit_valid && bit_ready;
    assign bit_out  = MSB_FIRST ? shreg[7] : shreg[0];
    assign bit_last = bit_valid && (bit_cnt == LAST_BIT) && (rd_addr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
        end else begin
            // NOTE: non-blocking defaults here make rd_en and done single-cycle
            // pulses unless a state below re-asserts them in the same edge.
            rd_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FETCH;
                        rd_addr <= '0;
                        rd_en   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    shreg     <= rd_data;
                    bit_cnt   <= '0;
                    bit_valid <= 1'b1;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    if (accept) begin
                        shreg   <= MSB_FIRST ? {shreg[6:0], fill} : {fill, shreg[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) begin
                            bit_valid <= 1'b0;
                            if (rd_addr == LAST_ADDR) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                rd_addr <= rd_addr + 4'd1;
                                rd_en   <= 1'b1;
                                state   <= FETCH;
                            end
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_output.sv
// Scoreboard bench for bit_output: two instances (LSB-first and MSB-first) share one stimulus stream.
// Expected bits are queued on each start; a negedge monitor pops and compares on every accepted bit.
module tb_bit_output;

    localparam int MSG_LEN = 2;
`ifdef BIT_OUTPUT_PARITY_EN
    localparam int BPB = 9;
`else
    localparam int BPB = 8;
`endif
    localparam int MSG_TIME = (BPB + 2) * MSG_LEN + 1;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       bit_ready;
    logic [1:0] rd_en, bit_out, bit_valid, bit_last, busy, done;
    logic [3:0] rd_addr [2];
    logic [7:0] rd_data [2];
    logic [7:0] mem [16];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   acc0 = 0;
    int   done_cnt [2] = '{0, 0};
    exp_t q0 [$];
    exp_t q1 [$];
    int   rd_log [$];

    logic [1:0] stall = 2'b00;
    logic [1:0] hold_bit, hold_last;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bit_output #(.MSG_LEN(MSG_LEN), .MSB_FIRST(g == 1)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start),
            .rd_en    (rd_en[g]),
            .rd_addr  (rd_addr[g]),
            .rd_data  (rd_data[g]),
            .bit_out  (bit_out[g]),
            .bit_valid(bit_valid[g]),
            .bit_ready(bit_ready),
            .bit_last (bit_last[g]),
            .busy     (busy[g]),
            .done     (done[g])
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 2; g++)
            if (rd_en[g]) rd_data[g] <= mem[rd_addr[g]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard pops, backpressure stability, done and read-address logging.
    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < 2; g++) begin
            if (!reset && stall[g]) begin
                check($sformatf("lane%0d hold valid", g), bit_valid[g], 1);
                check($sformatf("lane%0d hold bit", g), bit_out[g], hold_bit[g]);
                check($sformatf("lane%0d hold last", g), bit_last[g], hold_last[g]);
            end
            stall[g]     = !reset && bit_valid[g] === 1'b1 && !bit_ready;
            hold_bit[g]  = bit_out[g];
            hold_last[g] = bit_last[g];
            if (!reset && bit_valid[g] === 1'b1 && bit_ready) begin
                if (g == 0) acc0++;
                if ((g == 0 ? q0.size() : q1.size()) == 0) begin
                    check($sformatf("lane%0d unexpected bit", g), 1, 0);
                end else begin
                    e = (g == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("lane%0d bit", g), bit_out[g], e.b);
                    check($sformatf("lane%0d last", g), bit_last[g], e.last);
                end
            end
            if (!reset && done[g] === 1'b1) done_cnt[g]++;
        end
        if (!reset && rd_en[0] === 1'b1) rd_log.push_back(int'(rd_addr[0]));
    end

    task automatic push_msg();
        exp_t e;
        for (int i = 0; i < MSG_LEN; i++) begin
            for (int k = 0; k < BPB; k++) begin
                e.last = (i == MSG_LEN - 1) && (k == BPB - 1);
                e.b = (k < 8) ? mem[i][k] : ^mem[i];
                q0.push_back(e);
                e.b = (k < 8) ? mem[i][7-k] : ^mem[i];
                q1.push_back(e);
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int g = 0; g < 2; g++) begin
            check({tag, " rd_en"}, rd_en[g], 0);
            check({tag, " rd_addr"}, rd_addr[g], 0);
            check({tag, " bit_out"}, bit_out[g], 0);
            check({tag, " bit_valid"}, bit_valid[g], 0);
            check({tag, " bit_last"}, bit_last[g], 0);
            check({tag, " busy"}, busy[g], 0);
            check({tag, " done"}, done[g], 0);
        end
    endtask

    task automatic settle_and_check(input string tag, input int dones_before);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check({tag, " lane0 bits left"}, q0.size(), 0);
        check({tag, " lane1 bits left"}, q1.size(), 0);
        check({tag, " lane0 done count"}, done_cnt[0], dones_before + 1);
        check({tag, " lane1 done count"}, done_cnt[1], dones_before + 1);
        check({tag, " busy after"}, busy, 0);
    endtask

    // Issues one start pulse (optionally a second during the message) and an optional stall window.
    task automatic run_msg(input int dup_start, input int stall_at, input int stall_len,
                           output int t_valid, output int t_done);
        int t0;
        t_valid = -1;
        t_done  = -1;
        rd_log.delete();
        push_msg();
        start = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 400 && t_done < 0; i++) begin
            @(posedge clk);
            #1;
            start     = (cyc - t0 == dup_start);
            bit_ready = !((cyc - t0) >= stall_at && (cyc - t0) < stall_at + stall_len);
            if (t_valid < 0 && bit_valid[0]) t_valid = cyc - t0;
            if (done[0]) t_done = cyc - t0;
        end
        if (t_done < 0) check("done timeout", 0, 1);
        bit_ready = 1'b1;
        start = 1'b0;
    endtask

    task automatic check_rd_log(input string tag);
        check({tag, " rd_en pulses"}, rd_log.size(), MSG_LEN);
        for (int i = 0; i < rd_log.size() && i < MSG_LEN; i++)
            check({tag, " rd_addr seq"}, rd_log[i], i);
    endtask

    initial begin
        int tv, td, d0, d1, d2, t0;
        reset = 1'b1;
        start = 1'b0;
        bit_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic message, ready tied high: latency and total time.
        mem[0] = 8'hA5;
        mem[1] = 8'h3C;
        d0 = done_cnt[0];
        run_msg(-1, 1000, 0, tv, td);
        check("first valid latency", tv, 3);
        check("done time", td, MSG_TIME);
        check_rd_log("basic");
        settle_and_check("basic", d0);

        // Non-palindromic data, second start pulse while busy is ignored.
        mem[0] = 8'h01;
        mem[1] = 8'hC8;
        d0 = done_cnt[0];
        run_msg(5, 1000, 0, tv, td);
        check("dup start done time", td, MSG_TIME);
        check_rd_log("dup start");
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        settle_and_check("dup start", d0);

        // Backpressure for 5 cycles mid-byte.
        mem[0] = 8'h6B;
        mem[1] = 8'hF0;
        d0 = done_cnt[0];
        run_msg(-1, 6, 5, tv, td);
        check("stall done time", td, MSG_TIME + 5);
        settle_and_check("stall", d0);

        // start held high: back-to-back messages with one IDLE cycle between.
        mem[0] = 8'h80;
        mem[1] = 8'h0F;
        d0 = done_cnt[0];
        push_msg();
        push_msg();
        start = 1'b1;
        t0 = cyc;
        d1 = -1;
        d2 = -1;
        for (int i = 0; i < 400 && d2 < 0; i++) begin
            @(posedge clk);
            #1;
            if (done[0]) begin
                if (d1 < 0) d1 = cyc;
                else d2 = cyc;
            end
            if (d1 >= 0 && cyc == d1 + 1) check("held start idle busy", busy[0], 0);
            if (d1 >= 0 && cyc == d1 + 2) begin
                check("held start restart busy", busy[0], 1);
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (d2 < 0) check("held start timeout", 0, 1);
        check("held start first done", d1 - t0, MSG_TIME);
        check("held start second done", d2 - d1, MSG_TIME + 1);
        settle_and_check("held start", d0 + 1);

        // Reset while sending byte 1, bit 3: abort with no done.
        mem[0] = 8'h33;
        mem[1] = 8'h99;
        d0 = done_cnt[0];
        push_msg();
        start = 1'b1;
        t0 = acc0;
        tv = 0;
        for (int i = 0; i < 400 && tv == 0; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (acc0 - t0 == BPB + 3) tv = 1;
        end
        if (tv == 0) check("reset point timeout", 0, 1);
        reset = 1'b1;
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs_zero("mid reset");
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("mid reset no done", done_cnt[0], d0);
        check("mid reset idle valid", bit_valid, 0);

        // Restart after the abort begins again from address 0.
        mem[0] = 8'hE1;
        mem[1] = 8'h2D;
        d0 = done_cnt[0];
        run_msg(-1, 1000, 0, tv, td);
        check("restart latency", tv, 3);
        check("restart done time", td, MSG_TIME);
        check_rd_log("restart");
        settle_and_check("restart", d0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
